// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: holds user reset until PLL lock has been stable, then releases it.
// Lock loss from RUN re-asserts the reset and is counted (saturating).
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int CNT_W              = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  output logic             rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] lost_lock_cnt
);
  localparam int MAX_C = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);
  typedef enum logic [2:0] {IDLE, WAIT_LOCK, STABLE, HOLD, RUN} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] rst_sync_q, lock_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lost_q, lost_d;
  logic rst_out_q, ready_q, rst_s, lock_s, counting;
  assign rst_s = rst_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign counting = (state_q == STABLE) || (state_q == HOLD);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = rst_s ? WAIT_LOCK : IDLE;
      WAIT_LOCK: state_d = lock_s ? STABLE : WAIT_LOCK;
      STABLE:    state_d = !lock_s ? WAIT_LOCK : (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) ? HOLD : STABLE;
      HOLD:      state_d = !lock_s ? WAIT_LOCK : (cnt_q == CW'(RST_HOLD_CYCLES - 1)) ? RUN : HOLD;
      RUN:       state_d = lock_s ? RUN : WAIT_LOCK;
      default:   state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || !counting) ? '0 : cnt_q + CW'(1);
    // Only a loss out of RUN is a counted event; losses during qualification are not.
    lost_d = (state_q == RUN && !lock_s && lost_q != '1) ? lost_q + CNT_W'(1) : lost_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      lost_q      <= '0;
      rst_out_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lost_q      <= lost_d;
      rst_out_q   <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
    end
  end
  assign rst_out = rst_out_q;
  assign ready = ready_q;
  assign lost_lock_cnt = lost_q;
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: run-length reference model feeds an expectation queue; monitors compare.
module tb_pll_lock_reset_seq;
  localparam int S = 2, LS = 8, RH = 4, CW = 2, N = LS + RH + 1;
  typedef struct packed {logic r; logic y; logic [CW-1:0] c;} exp_t;
  logic clk = 1'b0, rst_n = 1'b1, pll_lock = 1'b1;
  logic rst_out, ready;
  logic [CW-1:0] lost_lock_cnt;
  int total = 0, bad = 0;
  int k = 0, r = 0, lost = 0;
  logic hist[$];
  logic lv;
  bit was;
  exp_t sq[$], aq[$];
  exp_t me, ae;
  event aev;
  pll_lock_reset_seq #(.SYNC_STAGES(S), .LOCK_STABLE_CYCLES(LS), .RST_HOLD_CYCLES(RH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
    .rst_out(rst_out), .ready(ready), .lost_lock_cnt(lost_lock_cnt));
  always #5 clk = ~clk;
  // Reference: the user reset is released once the synced lock has been 1 for
  // LS+RH+1 consecutive qualifying edges; a 0 after such a run is a counted loss.
  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0; r = 0; lost = 0; hist = {};
    end else begin
      k++;
      lv = (hist.size() == S) ? hist.pop_front() : 1'b0;
      hist.push_back(pll_lock);
      if (k >= S + 2) begin
        was = (r >= N);
        r = lv ? r + 1 : 0;
        if (was && !lv && lost < 2**CW - 1) lost++;
      end
    end
    sq.push_back({r < N, r >= N, CW'(lost)});
  end
  task automatic check(string n, exp_t e);
    total++;
    if ({rst_out, ready, lost_lock_cnt} !== e) begin
      bad++;
      $display("FAIL %s t=%0t rst_out/ready/cnt got %b/%b/%0d want %b/%b/%0d",
               n, $time, rst_out, ready, lost_lock_cnt, e.r, e.y, e.c);
    end
  endtask
  always @(negedge clk) if (sq.size() != 0) begin
    me = sq.pop_front();
    check("cycle", me);
  end
  always @(aev) while (aq.size() != 0) begin
    ae = aq.pop_front();
    check("async_reset", ae);
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic areset();
    rst_n = 1'b0;
    #1;
    aq.push_back({1'b1, 1'b0, CW'(0)});
    ->aev;
  endtask
  initial begin
    #1 areset();
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    pll_lock = 1'b0; cyc(3); pll_lock = 1'b1; cyc(16);
    pll_lock = 1'b0; cyc(3); pll_lock = 1'b1; cyc(8);
    pll_lock = 1'b0; cyc(2); pll_lock = 1'b1; cyc(20);
    areset(); cyc(2); rst_n = 1'b1; cyc(18);
    repeat (4) begin
      pll_lock = 1'b0; cyc($urandom_range(1, 4));
      pll_lock = 1'b1; cyc(16);
    end
    areset(); cyc(2); rst_n = 1'b1; cyc(13);
    areset(); cyc(2); rst_n = 1'b1; cyc(20);
    repeat (60) begin
      if ($urandom_range(0, 9) == 0) begin
        areset(); cyc($urandom_range(1, 3)); rst_n = 1'b1;
      end
      pll_lock = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(1, 20));
    end
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
